// File: rtl/game_round_controller_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg: shared types and constants for the binary-equivalent game round
// controller.
//   - FSM state codes (legacy-compatible 3-bit constants)
//   - level encoding, per-level target limits, score step
//   - sat_add16: 16-bit saturating adder used by the scoring path
// -----------------------------------------------------------------------------
package game_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_GET   = 3'd1;
    localparam state_t ST_PLAY  = 3'd2;
    localparam state_t ST_CHECK = 3'd3;
    localparam state_t ST_HIT   = 3'd4;
    localparam state_t ST_MISS  = 3'd5;
    localparam state_t ST_WIN   = 3'd6;
    localparam state_t ST_LOSE  = 3'd7;

    localparam logic [1:0] LEVEL_NONE = 2'd0;
    localparam logic [1:0] LEVEL_1    = 2'd1;
    localparam logic [1:0] LEVEL_2    = 2'd2;
    localparam logic [1:0] LEVEL_3    = 2'd3;

    localparam logic [7:0] LIMIT_L1 = 8'd9;
    localparam logic [7:0] LIMIT_L2 = 8'd99;
    localparam logic [7:0] LIMIT_L3 = 8'd255;

    localparam logic [15:0] SCORE_STEP = 16'd100;

    // Largest target value shown as a decimal for the given level.
    function automatic logic [7:0] level_limit(input logic [1:0] lvl);
        logic [7:0] lim;
        case (lvl)
            LEVEL_1: lim = LIMIT_L1;
            LEVEL_2: lim = LIMIT_L2;
            LEVEL_3: lim = LIMIT_L3;
            default: lim = 8'd0;
        endcase
        return lim;
    endfunction

    // Add two 16-bit values, clamping at 16'hFFFF instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/game_round_controller_if.sv
// -----------------------------------------------------------------------------
// game_round_controller_if: bundle of the game controller's event inputs,
// random-source handshake and display/status outputs.
//   master modport: environment side (drives tick/start/submit/guess/rand_*)
//   slave  modport: controller side (drives rand_req, target, level, time_left,
//                   lives, score, win, lose)
// -----------------------------------------------------------------------------
interface game_round_controller_if;

    logic        tick_1hz;
    logic        start;
    logic        submit;
    logic [7:0]  guess;
    logic        rand_ack;
    logic [7:0]  rand_val;
    logic        rand_req;
    logic [7:0]  target;
    logic [1:0]  level;
    logic [5:0]  time_left;
    logic [2:0]  lives;
    logic [15:0] score;
    logic        win;
    logic        lose;

    modport master (
        output tick_1hz, start, submit, guess, rand_ack, rand_val,
        input  rand_req, target, level, time_left, lives, score, win, lose
    );

    modport slave (
        input  tick_1hz, start, submit, guess, rand_ack, rand_val,
        output rand_req, target, level, time_left, lives, score, win, lose
    );

endinterface

// File: rtl/game_round_controller_round_timer.sv
// -----------------------------------------------------------------------------
// round_timer: loadable 6-bit seconds down-counter.
//   clk, reset (async active-low)
//   load / load_val : load a new countdown value (has priority over tick)
//   tick_en         : decrement by one; holds at zero
//   count           : current value (registered)
//   zero            : count == 0
// -----------------------------------------------------------------------------
module round_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [5:0] load_val,
    input  logic       tick_en,
    output logic [5:0] count,
    output logic       zero
);

    logic [5:0] count_r;

    // Countdown register: load, decrement on enabled tick, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= 6'd0;
        end else if (load) begin
            count_r <= load_val;
        end else if (tick_en && (count_r != 6'd0)) begin
            count_r <= count_r - 6'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign zero  = (count_r == 6'd0);

endmodule

// File: rtl/game_round_controller.sv
// -----------------------------------------------------------------------------
// game_round_controller: round sequencer for the binary-equivalent game.
// Fetches a level-limited random target, runs the per-level countdown, judges
// the switch guess and maintains score, lives (thermometer code) and level.
//   clk, reset (async active-low)
//   bus (slave modport): tick_1hz, start, submit, guess, rand_ack, rand_val in;
//                        rand_req, target, level, time_left, lives, score,
//                        win, lose out (all registered)
// Optional build macro: GAME_TIME_BONUS_EN - a hit also adds the remaining
// seconds to the score.
// -----------------------------------------------------------------------------
module game_round_controller
    import game_pkg::*;
#(
    parameter int unsigned L1_TIME          = 30,
    parameter int unsigned L2_TIME          = 40,
    parameter int unsigned L3_TIME          = 50,
    parameter int unsigned START_LIVES      = 3,
    parameter int unsigned ROUNDS_PER_LEVEL = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    game_round_controller_if.slave bus
);

    localparam logic [5:0] L1_T       = 6'(L1_TIME);
    localparam logic [5:0] L2_T       = 6'(L2_TIME);
    localparam logic [5:0] L3_T       = 6'(L3_TIME);
    localparam logic [2:0] LIVES_INIT = 3'((8'd1 << START_LIVES) - 8'd1);
    localparam logic [3:0] ROUNDS_C   = 4'(ROUNDS_PER_LEVEL);

    state_t      state_r;
    logic        rand_req_r;
    logic [7:0]  target_r;
    logic [7:0]  guess_r;
    logic [1:0]  level_r;
    logic [2:0]  lives_r;
    logic [15:0] score_r;
    logic        win_r;
    logic        lose_r;
    logic [3:0]  round_cnt_r;

    logic        rand_fire_s;
    logic        accept_s;
    logic [5:0]  level_time_s;
    logic [15:0] step_s;
    logic [15:0] score_next_s;
    logic [3:0]  round_next_s;
    logic        timer_tick_s;
    logic [5:0]  time_left_s;
    logic        time_zero_s;
    logic        timeout_s;

    // A random value is only consumed while a request is outstanding.
    assign rand_fire_s  = (state_r == ST_GET) && rand_req_r && bus.rand_ack;
    // Range check against the level limit replaces any modulo reduction.
    assign accept_s     = (bus.rand_val <= level_limit(level_r));
    // A simultaneous submit freezes the clock so the bonus sees the submit-time value.
    assign timer_tick_s = (state_r == ST_PLAY) && bus.tick_1hz && !bus.submit;
    // time_zero_s is a guard: PLAY should never be reached with an empty timer.
    assign timeout_s    = (bus.tick_1hz && (time_left_s == 6'd1)) || time_zero_s;
    assign round_next_s = round_cnt_r + 4'd1;

    // Countdown length for the current level.
    always_comb begin
        level_time_s = L1_T;
        case (level_r)
            LEVEL_1: level_time_s = L1_T;
            LEVEL_2: level_time_s = L2_T;
            LEVEL_3: level_time_s = L3_T;
            default: level_time_s = L1_T;
        endcase
    end

    // Score step 100 x level, built from shifts and adds of the base step.
    always_comb begin
        step_s = 16'd0;
        case (level_r)
            LEVEL_1: step_s = SCORE_STEP;
            LEVEL_2: step_s = SCORE_STEP << 1;
            LEVEL_3: step_s = SCORE_STEP + (SCORE_STEP << 1);
            default: step_s = 16'd0;
        endcase
    end

    // Next score on a hit, saturating at 16'hFFFF.
    always_comb begin
        score_next_s = score_r;
`ifdef GAME_TIME_BONUS_EN
        score_next_s = sat_add16(sat_add16(score_r, step_s), {10'd0, time_left_s});
`else
        score_next_s = sat_add16(score_r, step_s);
`endif
    end

    round_timer u_round_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (rand_fire_s && accept_s),
        .load_val (level_time_s),
        .tick_en  (timer_tick_s),
        .count    (time_left_s),
        .zero     (time_zero_s)
    );

    // Round sequencer FSM and the registered game status it owns.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            rand_req_r  <= 1'b0;
            target_r    <= 8'd0;
            guess_r     <= 8'd0;
            level_r     <= LEVEL_NONE;
            lives_r     <= 3'd0;
            score_r     <= 16'd0;
            win_r       <= 1'b0;
            lose_r      <= 1'b0;
            round_cnt_r <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    if (bus.start) begin
                        state_r     <= ST_GET;
                        rand_req_r  <= 1'b1;
                        level_r     <= LEVEL_1;
                        score_r     <= 16'd0;
                        lives_r     <= LIVES_INIT;
                        round_cnt_r <= 4'd0;
                        win_r       <= 1'b0;
                        lose_r      <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_GET: begin
                    // Drop the request after each ack; a rejected value
                    // re-raises it on the following cycle.
                    if (rand_fire_s) begin
                        rand_req_r <= 1'b0;
                        if (accept_s) begin
                            target_r <= bus.rand_val;
                            state_r  <= ST_PLAY;
                        end else begin
                            state_r <= ST_GET;
                        end
                    end else begin
                        rand_req_r <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (bus.submit) begin
                        guess_r <= bus.guess;
                        state_r <= ST_CHECK;
                    end else if (timeout_s) begin
                        state_r <= ST_MISS;
                    end else begin
                        state_r <= ST_PLAY;
                    end
                end
                ST_CHECK: begin
                    state_r <= (guess_r == target_r) ? ST_HIT : ST_MISS;
                end
                ST_HIT: begin
                    score_r <= score_next_s;
                    if (round_next_s >= ROUNDS_C) begin
                        if (level_r != LEVEL_3) begin
                            level_r     <= level_r + 2'd1;
                            round_cnt_r <= 4'd0;
                            rand_req_r  <= 1'b1;
                            state_r     <= ST_GET;
                        end else begin
                            round_cnt_r <= round_next_s;
                            win_r       <= 1'b1;
                            state_r     <= ST_WIN;
                        end
                    end else begin
                        round_cnt_r <= round_next_s;
                        rand_req_r  <= 1'b1;
                        state_r     <= ST_GET;
                    end
                end
                ST_MISS: begin
                    lives_r <= lives_r >> 1;
                    if (lives_r[2:1] == 2'b00) begin
                        lose_r  <= 1'b1;
                        state_r <= ST_LOSE;
                    end else begin
                        rand_req_r <= 1'b1;
                        state_r    <= ST_GET;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rand_req  = rand_req_r;
    assign bus.target    = target_r;
    assign bus.level     = level_r;
    assign bus.time_left = time_left_s;
    assign bus.lives     = lives_r;
    assign bus.score     = score_r;
    assign bus.win       = win_r;
    assign bus.lose      = lose_r;

endmodule
